// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the front-end hazard/flush sequencer: FSM encoding,
// register-index width, the bundle of pipeline control outputs and the load-use compare.
package pipe_ctrl_pkg;

  localparam int unsigned REG_IDX_W = 5;
  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    RELEASE = 2'd3
  } state_e;

  typedef struct packed {
    logic pc_write;
    logic ifid_hazard;
    logic ifid_flush;
    logic idex_bubble;
    logic cgra_start;
  } ctrl_t;

  localparam ctrl_t CTRL_RUN   = 5'b10000;
  localparam ctrl_t CTRL_STALL = 5'b01010;
  localparam ctrl_t CTRL_ISSUE = 5'b01011;
  localparam ctrl_t CTRL_FLUSH = 5'b10110;

  // x0 is hardwired to zero, so a load targeting it never creates a dependency.
  function automatic logic load_use(input logic ex_memread, input reg_idx_t ex_rd,
                                    input logic use_rs1, input reg_idx_t rs1,
                                    input logic use_rs2, input reg_idx_t rs2);
    return ex_memread && (ex_rd != '0) &&
           ((use_rs1 && (rs1 == ex_rd)) || (use_rs2 && (rs2 == ex_rd)));
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-side bundle of the hazard sequencer: ID/EX operand info, CGRA handshake,
// stall/flush controls and performance counters.
interface pipe_hazard_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  pipe_ctrl_pkg::reg_idx_t id_rs1_i;
  pipe_ctrl_pkg::reg_idx_t id_rs2_i;
  logic                    id_use_rs1_i;
  logic                    id_use_rs2_i;
  logic                    id_cgra_i;
  pipe_ctrl_pkg::reg_idx_t ex_rd_i;
  logic                    ex_memread_i;
  logic                    branch_taken_i;
  logic                    cgra_done_i;

  logic                    pc_write_o;
  logic                    ifid_hazard_o;
  logic                    ifid_flush_o;
  logic                    idex_bubble_o;
  logic                    cgra_start_o;
  logic                    cgra_timeout_o;
  logic [CNT_W-1:0]        stall_cnt_o;
  logic [CNT_W-1:0]        flush_cnt_o;

  modport master (
    output id_rs1_i, id_rs2_i, id_use_rs1_i, id_use_rs2_i, id_cgra_i,
           ex_rd_i, ex_memread_i, branch_taken_i, cgra_done_i,
    input  pc_write_o, ifid_hazard_o, ifid_flush_o, idex_bubble_o,
           cgra_start_o, cgra_timeout_o, stall_cnt_o, flush_cnt_o
  );

  modport slave (
    input  id_rs1_i, id_rs2_i, id_use_rs1_i, id_use_rs2_i, id_cgra_i,
           ex_rd_i, ex_memread_i, branch_taken_i, cgra_done_i,
    output pc_write_o, ifid_hazard_o, ifid_flush_o, idex_bubble_o,
           cgra_start_o, cgra_timeout_o, stall_cnt_o, flush_cnt_o
  );
endinterface

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter used for the stall and flush performance counters.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] value
);

  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
    end else if (inc && (value != '1)) begin
      value <= value + W'(1);
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Front-end hazard/flush sequencer: load-use stalls, branch flushes and the
// IDLE/ISSUE/WAIT/RELEASE hold sequence for CGRA custom instructions.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned CGRA_TIMEOUT = 1024,
  parameter int unsigned CNT_W        = 32
) (
  input  logic              clk_i,
  input  logic              start_i,
  pipe_hazard_ctrl_if.slave bus
);

  localparam int unsigned TO_W = (CGRA_TIMEOUT > 2) ? $clog2(CGRA_TIMEOUT) : 1;

  state_e          state, state_nxt;
  ctrl_t           ctrl;
  logic [TO_W-1:0] to_cnt;
  logic            timeout_flag;
  logic            lu;
  logic            timeout_hit;

  assign lu = load_use(bus.ex_memread_i, bus.ex_rd_i,
                       bus.id_use_rs1_i, bus.id_rs1_i,
                       bus.id_use_rs2_i, bus.id_rs2_i);

  // WAIT lasts CGRA_TIMEOUT cycles: the counter is cleared in ISSUE and the
  // last permitted WAIT cycle is the one that sees CGRA_TIMEOUT-1.
  assign timeout_hit = (to_cnt == TO_W'(CGRA_TIMEOUT - 1));

  always_ff @(posedge clk_i or negedge start_i) begin
    if (!start_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk_i or negedge start_i) begin
    if (!start_i) begin
      to_cnt       <= '0;
      timeout_flag <= 1'b0;
    end else begin
      if (state == ISSUE) begin
        to_cnt <= '0;
      end else if (state == WAIT) begin
        to_cnt <= to_cnt + TO_W'(1);
      end
      // A completion in the final WAIT cycle wins over the timeout.
      if ((state == WAIT) && !bus.cgra_done_i && timeout_hit) begin
        timeout_flag <= 1'b1;
      end
    end
  end

  // NOTE: every signal written here gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    ctrl      = CTRL_RUN;
    case (state)
      IDLE: begin
        if (bus.branch_taken_i) begin
          ctrl = CTRL_FLUSH;
        end else if (lu) begin
          ctrl = CTRL_STALL;
        end else if (bus.id_cgra_i) begin
          ctrl      = CTRL_STALL;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        ctrl      = CTRL_ISSUE;
        state_nxt = bus.cgra_done_i ? RELEASE : WAIT;
      end
      WAIT: begin
        ctrl = CTRL_STALL;
        if (bus.cgra_done_i || timeout_hit) begin
          state_nxt = RELEASE;
        end
      end
      RELEASE: begin
        state_nxt = IDLE;
      end
    endcase
    // The Mealy IDLE decode must not leak stalls or flushes while held in reset.
    if (!start_i) begin
      ctrl = CTRL_RUN;
    end
  end

  assign bus.pc_write_o     = ctrl.pc_write;
  assign bus.ifid_hazard_o  = ctrl.ifid_hazard;
  assign bus.ifid_flush_o   = ctrl.ifid_flush;
  assign bus.idex_bubble_o  = ctrl.idex_bubble;
  assign bus.cgra_start_o   = ctrl.cgra_start;
  assign bus.cgra_timeout_o = timeout_flag;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk_i),
    .rst_n (start_i),
    .inc   (!ctrl.pc_write),
    .value (bus.stall_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk_i),
    .rst_n (start_i),
    .inc   (ctrl.ifid_flush),
    .value (bus.flush_cnt_o)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: IDLE decode table, directed CGRA,
// timeout, reset and saturation sequences, and randomized traffic against a model.
module tb_pipe_hazard_ctrl;

  localparam int unsigned TO      = 8;
  localparam int unsigned CNT_W   = 6;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;

  // Control vector order: {pc_write, ifid_hazard, ifid_flush, idex_bubble, cgra_start}
  localparam logic [4:0] C_RUN   = 5'b10000;
  localparam logic [4:0] C_STALL = 5'b01010;
  localparam logic [4:0] C_ISSUE = 5'b01011;
  localparam logic [4:0] C_FLUSH = 5'b10110;

  logic clk_i   = 1'b0;
  logic start_i = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipe_hazard_ctrl #(.CGRA_TIMEOUT(TO), .CNT_W(CNT_W)) dut (
    .clk_i   (clk_i),
    .start_i (start_i),
    .bus     (bus)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached, n_fail=%0d", n_fail);
    $fatal(1, "watchdog");
  end

  // Reference model: m_age counts cycles into a CGRA hold (0 = none, 1 = start
  // cycle, k>=2 = (k-2) cycles already waited); m_release marks the hand-back cycle.
  int         m_age;
  bit         m_release;
  bit         m_timeout;
  int         m_stall;
  int         m_flush;
  logic [4:0] obs_ctrl;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] act_ctrl();
    return {bus.pc_write_o, bus.ifid_hazard_o, bus.ifid_flush_o,
            bus.idex_bubble_o, bus.cgra_start_o};
  endfunction

  function automatic bit lu_ref();
    if (!bus.ex_memread_i || bus.ex_rd_i == 5'd0) return 1'b0;
    return (bus.id_use_rs1_i && bus.id_rs1_i == bus.ex_rd_i) ||
           (bus.id_use_rs2_i && bus.id_rs2_i == bus.ex_rd_i);
  endfunction

  function automatic logic [4:0] expect_ctrl();
    if (!start_i || m_release) return C_RUN;
    if (m_age == 1) return C_ISSUE;
    if (m_age >= 2) return C_STALL;
    if (bus.branch_taken_i) return C_FLUSH;
    if (lu_ref() || bus.id_cgra_i) return C_STALL;
    return C_RUN;
  endfunction

  task automatic model_reset();
    m_age     = 0;
    m_release = 1'b0;
    m_timeout = 1'b0;
    m_stall   = 0;
    m_flush   = 0;
  endtask

  task automatic model_advance();
    logic [4:0] e;
    e = expect_ctrl();
    if (!e[4] && m_stall < CNT_MAX) m_stall++;
    if (e[2] && m_flush < CNT_MAX) m_flush++;
    if (m_release) begin
      m_release = 1'b0;
    end else if (m_age == 1) begin
      if (bus.cgra_done_i) begin
        m_age = 0; m_release = 1'b1;
      end else begin
        m_age = 2;
      end
    end else if (m_age >= 2) begin
      if (bus.cgra_done_i) begin
        m_age = 0; m_release = 1'b1;
      end else if (m_age - 2 == int'(TO) - 1) begin
        m_age = 0; m_release = 1'b1; m_timeout = 1'b1;
      end else begin
        m_age++;
      end
    end else if (!bus.branch_taken_i && !lu_ref() && bus.id_cgra_i) begin
      m_age = 1;
    end
  endtask

  task automatic idle_inputs();
    bus.id_rs1_i       = '0;
    bus.id_rs2_i       = '0;
    bus.id_use_rs1_i   = 1'b0;
    bus.id_use_rs2_i   = 1'b0;
    bus.id_cgra_i      = 1'b0;
    bus.ex_rd_i        = '0;
    bus.ex_memread_i   = 1'b0;
    bus.branch_taken_i = 1'b0;
    bus.cgra_done_i    = 1'b0;
  endtask

  task automatic lu_inputs();
    idle_inputs();
    bus.ex_memread_i = 1'b1;
    bus.ex_rd_i      = 5'd5;
    bus.id_rs1_i     = 5'd5;
    bus.id_use_rs1_i = 1'b1;
  endtask

  // One clock cycle: inputs are already set; compare at negedge, advance model at posedge.
  task automatic run_cycle(input string tag);
    @(negedge clk_i);
    obs_ctrl = act_ctrl();
    check({tag, "_ctrl"}, 32'(obs_ctrl), 32'(expect_ctrl()));
    check({tag, "_stall_cnt"}, 32'(bus.stall_cnt_o), 32'(m_stall));
    check({tag, "_flush_cnt"}, 32'(bus.flush_cnt_o), 32'(m_flush));
    check({tag, "_timeout"}, 32'(bus.cgra_timeout_o), 32'(m_timeout));
    @(posedge clk_i);
    assert (!(bus.branch_taken_i && m_age != 0))
      else $error("protocol violation: branch_taken_i during CGRA hold");
    assert (!(bus.cgra_done_i && m_age == 0))
      else $error("protocol violation: cgra_done_i outside ISSUE/WAIT");
    model_advance();
    #1;
  endtask

  // Called just after a posedge; asserts reset asynchronously and checks forced values.
  task automatic do_reset();
    start_i = 1'b0;
    #1;
    check("rst_ctrl", 32'(act_ctrl()), 32'(C_RUN));
    check("rst_stall_cnt", 32'(bus.stall_cnt_o), 32'd0);
    check("rst_flush_cnt", 32'(bus.flush_cnt_o), 32'd0);
    check("rst_timeout", 32'(bus.cgra_timeout_o), 32'd0);
    model_reset();
    @(posedge clk_i);
    #1;
    idle_inputs();
    start_i = 1'b1;
  endtask

  task automatic rand_inputs();
    bus.id_rs1_i       = 5'($urandom_range(0, 3));
    bus.id_rs2_i       = 5'($urandom_range(0, 3));
    bus.id_use_rs1_i   = 1'($urandom_range(0, 1));
    bus.id_use_rs2_i   = 1'($urandom_range(0, 1));
    bus.ex_rd_i        = 5'($urandom_range(0, 3));
    bus.ex_memread_i   = ($urandom_range(0, 2) == 0);
    bus.id_cgra_i      = ($urandom_range(0, 4) == 0);
    bus.branch_taken_i = (m_age == 0) && ($urandom_range(0, 5) == 0);
    bus.cgra_done_i    = (m_age >= 1) && ($urandom_range(0, 5) == 0);
  endtask

  typedef struct {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       use1;
    logic       use2;
    logic       cgra;
    logic [4:0] rd;
    logic       mem;
    logic       br;
    logic [4:0] exp;
  } vec_t;

  vec_t vecs[11];

  logic [7:0] pc_hist, st_hist;
  int         rel_cycle;
  int         stall_cycles;

  initial begin
    vecs[0]  = '{5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, C_RUN};
    vecs[1]  = '{5'd5,  5'd0,  1'b1, 1'b0, 1'b0, 5'd5,  1'b1, 1'b0, C_STALL};
    vecs[2]  = '{5'd0,  5'd0,  1'b1, 1'b0, 1'b0, 5'd0,  1'b1, 1'b0, C_RUN};
    vecs[3]  = '{5'd5,  5'd0,  1'b0, 1'b0, 1'b0, 5'd5,  1'b1, 1'b0, C_RUN};
    vecs[4]  = '{5'd0,  5'd7,  1'b0, 1'b1, 1'b0, 5'd7,  1'b1, 1'b0, C_STALL};
    vecs[5]  = '{5'd0,  5'd7,  1'b0, 1'b1, 1'b0, 5'd7,  1'b0, 1'b0, C_RUN};
    vecs[6]  = '{5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 5'd0,  1'b0, 1'b1, C_FLUSH};
    vecs[7]  = '{5'd5,  5'd0,  1'b1, 1'b0, 1'b0, 5'd5,  1'b1, 1'b1, C_FLUSH};
    vecs[8]  = '{5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 5'd0,  1'b0, 1'b0, C_STALL};
    vecs[9]  = '{5'd30, 5'd31, 1'b1, 1'b1, 1'b0, 5'd31, 1'b1, 1'b0, C_STALL};
    vecs[10] = '{5'd3,  5'd4,  1'b0, 1'b1, 1'b0, 5'd3,  1'b1, 1'b0, C_RUN};

    idle_inputs();
    model_reset();
    #1;
    do_reset();

    // IDLE decode table, applied within the low clock phase so no edge sees it.
    for (int i = 0; i < 11; i++) begin
      @(negedge clk_i);
      bus.id_rs1_i       = vecs[i].rs1;
      bus.id_rs2_i       = vecs[i].rs2;
      bus.id_use_rs1_i   = vecs[i].use1;
      bus.id_use_rs2_i   = vecs[i].use2;
      bus.id_cgra_i      = vecs[i].cgra;
      bus.ex_rd_i        = vecs[i].rd;
      bus.ex_memread_i   = vecs[i].mem;
      bus.branch_taken_i = vecs[i].br;
      #1;
      check($sformatf("idle_vec%0d", i), 32'(act_ctrl()), 32'(vecs[i].exp));
      idle_inputs();
    end
    @(posedge clk_i);
    #1;
    check("table_no_count", 32'(bus.stall_cnt_o), 32'd0);

    // Load-use: exactly one stall cycle, then the same with rd=x0.
    lu_inputs();
    run_cycle("lu");
    check("lu_stall_seen", 32'(obs_ctrl), 32'(C_STALL));
    idle_inputs();
    run_cycle("lu_after");
    check("lu_one_cycle", 32'(obs_ctrl), 32'(C_RUN));
    check("lu_stall_cnt", 32'(bus.stall_cnt_o), 32'd1);
    lu_inputs();
    bus.ex_rd_i  = 5'd0;
    bus.id_rs1_i = 5'd0;
    run_cycle("lu_x0");
    check("lu_x0_no_stall", 32'(obs_ctrl), 32'(C_RUN));
    check("lu_x0_cnt", 32'(bus.stall_cnt_o), 32'd1);

    // Branch beats a pending CGRA instruction.
    do_reset();
    bus.branch_taken_i = 1'b1;
    bus.id_cgra_i      = 1'b1;
    run_cycle("br_cgra");
    check("br_cgra_flush", 32'(obs_ctrl), 32'(C_FLUSH));
    idle_inputs();
    for (int c = 0; c < 3; c++) begin
      run_cycle("br_cgra_after");
      check("br_cgra_no_start", 32'(obs_ctrl[0]), 32'd0);
    end
    check("br_cgra_flush_cnt", 32'(bus.flush_cnt_o), 32'd1);

    // CGRA normal: detect at 0, done at 5, release at 6, idle at 7.
    do_reset();
    for (int c = 0; c < 8; c++) begin
      idle_inputs();
      bus.id_cgra_i   = (c == 0);
      bus.cgra_done_i = (c == 5);
      run_cycle("cgra_norm");
      pc_hist[c] = obs_ctrl[4];
      st_hist[c] = obs_ctrl[0];
    end
    check("cgra_norm_pc", 32'(pc_hist), 32'h0000_00C0);
    check("cgra_norm_start", 32'(st_hist), 32'h0000_0002);
    check("cgra_norm_stall_cnt", 32'(bus.stall_cnt_o), 32'd6);

    // CGRA fast: done during ISSUE.
    do_reset();
    for (int c = 0; c < 4; c++) begin
      idle_inputs();
      bus.id_cgra_i   = (c == 0);
      bus.cgra_done_i = (c == 1);
      run_cycle("cgra_fast");
      pc_hist[c] = obs_ctrl[4];
    end
    check("cgra_fast_pc", 32'(pc_hist[3:0]), 32'h0000_000C);
    check("cgra_fast_stall_cnt", 32'(bus.stall_cnt_o), 32'd2);

    // Timeout: 8 WAIT cycles with no done, then RELEASE; flag is sticky.
    do_reset();
    idle_inputs();
    bus.id_cgra_i = 1'b1;
    run_cycle("to_detect");
    idle_inputs();
    rel_cycle    = -1;
    stall_cycles = 1;
    for (int c = 1; c < 20 && rel_cycle < 0; c++) begin
      run_cycle("to_hold");
      if (obs_ctrl[4]) rel_cycle = c;
      else stall_cycles++;
    end
    check("to_release_cycle", 32'(rel_cycle), 32'd10);
    check("to_stall_cycles", 32'(stall_cycles), 32'd10);
    check("to_flag_set", 32'(bus.cgra_timeout_o), 32'd1);
    for (int c = 0; c < 4; c++) begin
      idle_inputs();
      bus.id_cgra_i   = (c == 0);
      bus.cgra_done_i = (c == 1);
      run_cycle("to_next_op");
    end
    check("to_flag_sticky", 32'(bus.cgra_timeout_o), 32'd1);

    // Reset mid-WAIT with a load-use pattern on the inputs.
    do_reset();
    for (int c = 0; c < 4; c++) begin
      idle_inputs();
      bus.id_cgra_i = (c == 0);
      run_cycle("mid_wait");
    end
    lu_inputs();
    bus.id_cgra_i = 1'b1;
    do_reset();
    run_cycle("post_rst_idle");
    check("post_rst_run", 32'(obs_ctrl), 32'(C_RUN));
    bus.id_cgra_i = 1'b1;
    run_cycle("post_rst_detect");
    idle_inputs();
    bus.cgra_done_i = 1'b1;
    run_cycle("post_rst_issue");
    check("post_rst_start", 32'(obs_ctrl), 32'(C_ISSUE));
    idle_inputs();
    run_cycle("post_rst_release");

    // Saturation of both counters.
    do_reset();
    lu_inputs();
    for (int c = 0; c < CNT_MAX + 6; c++) run_cycle("sat_stall");
    check("sat_stall_cnt", 32'(bus.stall_cnt_o), 32'(CNT_MAX));
    idle_inputs();
    bus.branch_taken_i = 1'b1;
    for (int c = 0; c < CNT_MAX + 6; c++) run_cycle("sat_flush");
    check("sat_flush_cnt", 32'(bus.flush_cnt_o), 32'(CNT_MAX));
    check("sat_stall_hold", 32'(bus.stall_cnt_o), 32'(CNT_MAX));

    // Randomized traffic, reset between segments.
    for (int seg = 0; seg < 3; seg++) begin
      do_reset();
      for (int i = 0; i < 400; i++) begin
        rand_inputs();
        run_cycle("rand");
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
